// File: rtl/stack_pkg.sv
// stack_pkg: shared types and limits for the stack arbiter slice
package stack_pkg;
  typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} stack_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
  localparam int MAX_N = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] hi;
  logic [IW-1:0] lo;
  logic          hi_found;
  // hi is the lowest request at or above ptr; lo is the lowest overall, used on wrap
  always_comb begin
    hi       = '0;
    lo       = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i >= int'(ptr)) begin
        hi       = IW'(i);
        hi_found = 1'b1;
      end
      if (req[i]) lo = IW'(i);
    end
    gnt_idx = hi_found ? hi : lo;
    gnt     = (|req) ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin serialisation of push/pop requests onto one stack
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ_VALID,
  input  logic [N-1:0]   REQ_OP,
  input  logic [N*W-1:0] REQ_DATA,
  output logic [N-1:0]   REQ_READY,
  output logic [N-1:0]   RSP_VALID,
  output logic [W-1:0]   RSP_DATA,
  output logic           RSP_ERR,
  output logic           STK_PUSH,
  output logic           STK_POP,
  output logic [W-1:0]   STK_DIN,
  input  logic [W-1:0]   STK_DOUT,
  input  logic           STK_FULL,
  input  logic           STK_EMPTY
);
  localparam int IW = (N > 2) ? 2 : 1;
  arb_state_e    state;
  arb_state_e    state_nx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] g_q;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt;
  stack_op_e     op_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  rsp_q;
  logic          err_q;
  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req     (REQ_VALID),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end
  // every output is forced low while RST is high, even mid-transaction
  always_comb begin
    state_nx  = (state == IDLE) ? ((|REQ_VALID) ? ISSUE : IDLE) : (state == ISSUE) ? RESP : IDLE;
    REQ_READY = (!RST && state == IDLE) ? gnt : '0;
    STK_PUSH  = !RST && state == ISSUE && op_q == OP_PUSH && !STK_FULL;
    STK_POP   = !RST && state == ISSUE && op_q == OP_POP && !STK_EMPTY;
    STK_DIN   = STK_PUSH ? data_q : '0;
    RSP_VALID = (!RST && state == RESP) ? (N'(1) << g_q) : '0;
    RSP_DATA  = (!RST && state == RESP) ? rsp_q : '0;
    RSP_ERR   = !RST && state == RESP && err_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
      g_q    <= '0;
      op_q   <= OP_PUSH;
      data_q <= '0;
      rsp_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && |REQ_VALID) begin
        g_q    <= gnt_idx;
        op_q   <= stack_op_e'(REQ_OP[gnt_idx]);
        data_q <= REQ_DATA[int'(gnt_idx) * W +: W];
        rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == ISSUE) begin
        err_q <= !(STK_PUSH || STK_POP);
        rsp_q <= STK_POP ? STK_DOUT : '0;
      end
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed bench with a transaction-level reference model and a stack model
module tb_stack_arbiter;
  import stack_pkg::*;
  localparam int N = 2;
  localparam int W = 1;
  localparam int D = 4;
  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   REQ_VALID = '0;
  logic [N-1:0]   REQ_OP = '0;
  logic [N*W-1:0] REQ_DATA = '0;
  logic [N-1:0]   REQ_READY;
  logic [N-1:0]   RSP_VALID;
  logic [W-1:0]   RSP_DATA;
  logic           RSP_ERR;
  logic           STK_PUSH;
  logic           STK_POP;
  logic [W-1:0]   STK_DIN;
  logic [W-1:0]   STK_DOUT;
  logic           STK_FULL;
  logic           STK_EMPTY;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] env_mem [D];
  int env_cnt = 0;
  always #5 CLK = ~CLK;
  stack_arbiter #(.N(N), .W(W)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DIN(STK_DIN), .STK_DOUT(STK_DOUT),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
  );
  // the stack the arbiter drives; it is not cleared by RST
  always @(posedge CLK) begin
    if (STK_PUSH && env_cnt < D) begin
      env_mem[env_cnt] <= STK_DIN;
      env_cnt <= env_cnt + 1;
    end else if (STK_POP && env_cnt > 0) begin
      env_cnt <= env_cnt - 1;
    end
  end
  assign STK_FULL  = (env_cnt == D);
  assign STK_EMPTY = (env_cnt == 0);
  assign STK_DOUT  = (env_cnt > 0) ? env_mem[env_cnt - 1] : '0;
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  // reference: a transaction is accepted, issued one cycle later, answered the cycle after
  initial begin : model
    int ptr, age, mg, win;
    bit mop, mdat, merr, mrd;
    logic [N-1:0] e_ready, e_rv;
    logic e_rd, e_err, e_push, e_pop, e_din;
    logic [9:0] e_vec, a_vec;
    bit mstk[$];
    ptr = 0; age = 0; mg = 0; mop = 0; mdat = 0; merr = 0; mrd = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      e_ready = '0; e_rv = '0; e_rd = 0; e_err = 0; e_push = 0; e_pop = 0; e_din = 0;
      win = -1;
      if (!RST) begin
        if (age == 0)
          for (int k = 0; k < N; k++)
            if (win < 0 && REQ_VALID[(ptr + k) % N]) win = (ptr + k) % N;
        if (win >= 0) e_ready[win] = 1'b1;
        if (age == 1) begin
          if (!mop && mstk.size() < D) begin e_push = 1; e_din = mdat; end
          if (mop && mstk.size() > 0) e_pop = 1;
        end
        if (age == 2) begin e_rv[mg] = 1'b1; e_rd = mrd; e_err = merr; end
      end
      e_vec = {e_ready, e_rv, e_rd, e_err, e_push, e_pop, e_din, 1'(ptr)};
      a_vec = {REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, STK_PUSH, STK_POP, STK_DIN, dut.rr_ptr};
      checks++;
      if (a_vec !== e_vec) begin
        errors++;
        $display("FAIL cycle_outputs at %0t got %b expected %b (ready,rsp_valid,data,err,push,pop,din,ptr)", $time, a_vec, e_vec);
      end
      if (RST) begin
        age = 0; ptr = 0;
      end else if (age == 0) begin
        if (win >= 0) begin
          mg = win; mop = REQ_OP[win]; mdat = REQ_DATA[win * W]; ptr = (win + 1) % N; age = 1;
        end
      end else if (age == 1) begin
        merr = !(e_push || e_pop);
        mrd = e_pop ? mstk[$] : 1'b0;
        if (e_push) mstk.push_back(mdat);
        if (e_pop) void'(mstk.pop_back());
        age = 2;
      end else begin
        age = 0;
      end
    end
  end
  task automatic tick();
    @(posedge CLK); #1;
  endtask
  task automatic txn(input int i, input bit op, input bit d, input bit strobe, input bit rdata, input bit err);
    int n;
    REQ_VALID[i] = 1'b1; REQ_OP[i] = op; REQ_DATA[i] = d;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY[i] && n < 10) begin @(negedge CLK); n++; end
    lit("accept", int'(REQ_READY[i]), 1);
    tick();
    REQ_VALID[i] = 1'b0; REQ_DATA[i] = ~d; REQ_OP[i] = ~op;
    @(negedge CLK);
    lit("strobe", int'(op ? STK_POP : STK_PUSH), int'(strobe));
    lit("no_cross_strobe", int'(op ? STK_PUSH : STK_POP), 0);
    @(negedge CLK);
    lit("rsp_valid", int'(RSP_VALID), 1 << i);
    lit("rsp_data", int'(RSP_DATA), int'(rdata));
    lit("rsp_err", int'(RSP_ERR), int'(err));
    tick();
  endtask
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin : stim
    int n;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    repeat (5) tick();
    lit("idle_ptr", int'(dut.rr_ptr), 0);
    lit("idle_ready", int'(REQ_READY), 0);
    txn(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    txn(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    txn(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("empty_kept", env_cnt, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    REQ_VALID = 2'b11; REQ_OP = 2'b00; REQ_DATA = 2'b01;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      @(negedge CLK);
      while (REQ_READY == '0 && n < 10) begin @(negedge CLK); n++; end
      lit("grant_order", int'(REQ_READY), (g % 2 == 0) ? 1 : 2);
      tick();
      if (g == 3) REQ_VALID = 2'b00;
    end
    repeat (2) tick();
    lit("full_count", env_cnt, 4);
    lit("mem0", int'(env_mem[0]), 1);
    lit("mem1", int'(env_mem[1]), 0);
    lit("mem2", int'(env_mem[2]), 1);
    lit("mem3", int'(env_mem[3]), 0);
    txn(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    lit("full_kept", env_cnt, 4);
    txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    txn(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    REQ_VALID[0] = 1'b1; REQ_OP[0] = 1'b0; REQ_DATA[0] = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY[0] && n < 10) begin @(negedge CLK); n++; end
    lit("rst_accept", int'(REQ_READY[0]), 1);
    tick();
    REQ_VALID = '0;
    RST = 1'b1;
    @(negedge CLK);
    lit("rst_no_push", int'(STK_PUSH), 0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    lit("rst_no_rsp", int'(RSP_VALID), 0);
    lit("rst_ptr", int'(dut.rr_ptr), 0);
    lit("rst_state", int'(dut.state == IDLE), 1);
    lit("rst_stack", env_cnt, 2);
    repeat (2) tick();
    txn(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one `stack` instance between `N` requesters using round-robin arbitration.
- Each requester submits push or pop transactions through a valid/ready handshake.
- The arbiter serialises the transactions onto the stack's single-cycle `PUSH`/`POP` strobes.
- Each requester gets a one-cycle response carrying the popped data or an error flag.
- The block sits between the tile top level and `stack`, and is the only driver of the stack's control inputs.

## Interface
Parameters:
- `N`, 2: number of requesters, range 2..4.
- `W`, 1: data width; must match the stack's `DATA_IN`/`DATA_OUT` width.

Ports:
- `CLK`  in  1  clock. The block uses one clock; all logic is on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `REQ_VALID`  in  N  per-requester request valid.
- `REQ_OP`  in  N  per-requester operation: 0 = push, 1 = pop.
- `REQ_DATA`  in  N*W  push data; requester i uses bits [i*W +: W].
- `REQ_READY`  out  N  one-hot accept; at most one bit is high in any cycle.
- `RSP_VALID`  out  N  one-hot response strobe, one cycle long.
- `RSP_DATA`  out  W  popped data; meaningful only while a `RSP_VALID` bit is high.
- `RSP_ERR`  out  1  error flag, qualified by `RSP_VALID`: push to a full stack, or pop from an empty stack.
- `STK_PUSH`, `STK_POP`  out  1  drive stack `PUSH`/`POP`; never both high.
- `STK_DIN`  out  W  drives stack `DATA_IN`.
- `STK_DOUT`  in  W  from stack `DATA_OUT`; the top of stack when the stack is not empty.
- `STK_FULL`, `STK_EMPTY`  in  1  from the stack's status outputs.

## Operation
- The FSM has three states: `IDLE`, `ISSUE` and `RESP`.
- `IDLE`:
  - If any `REQ_VALID` is high, the round-robin arbiter picks the winner g: the first valid requester at or after `rr_ptr`, searching modulo N.
  - `REQ_READY[g]` goes high combinationally in that same cycle, and the handshake completes in that cycle.
  - The block latches g, `REQ_OP[g]` and `REQ_DATA[g]`, sets `rr_ptr <= (g+1) mod N`, and moves to `ISSUE`.
  - If no `REQ_VALID` is high, the block stays in `IDLE` and `rr_ptr` is held.
- `ISSUE`:
  - The latched operation is checked against `STK_FULL`/`STK_EMPTY` as sampled in this cycle.
  - Push with `STK_FULL`=0: `STK_PUSH`=1 and `STK_DIN`=latched data.
  - Pop with `STK_EMPTY`=0: `STK_POP`=1, and `STK_DOUT` is captured into the response register in the same cycle.
  - Otherwise no strobe is issued; the error bit is set and the response data is 0.
  - The block then moves to `RESP`.
- `RESP`:
  - `RSP_VALID[g]`=1, `RSP_DATA` shows the captured value (0 for a push or an error), and `RSP_ERR` shows the error bit.
  - The block returns to `IDLE`.
  - No request is accepted in this cycle.
- Throughput: one transaction per 3 cycles.
- Requesters must not retract `REQ_VALID` before `REQ_READY`. The arbiter never drops an accepted request.
- Once accepted, the transaction's operation and data are fixed; changes to the request inputs afterwards have no effect.

## Timing
- Reset values: state `IDLE`, `rr_ptr`=0, latched registers 0.
  - During reset, all outputs are 0, including `STK_PUSH`, `STK_POP` and `REQ_READY`.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no `RSP_VALID` is produced.
  - If reset is high during the `ISSUE` cycle, no stack strobe is issued.
- Latency: accept in cycle T, stack strobe in T+1, `RSP_VALID` in T+2.
- `STK_PUSH`/`STK_POP` are registered-state decodes, high only in `ISSUE` and for exactly one cycle.
- Simultaneous requests: exactly one is granted per `IDLE` cycle; the losers wait with `REQ_VALID` held.
- Starvation bound: a continuously valid requester is granted within N transactions.
- Full/empty boundary: the check uses the flags in the `ISSUE` cycle. The stack changes only through this block, so the flags cannot change between accept and issue.

## Structure
- `stack_pkg` holds:
  - the `stack_op_e` enum: `OP_PUSH`=0, `OP_POP`=1;
  - the `arb_state_e` enum: `IDLE`, `ISSUE`, `RESP`;
  - `localparam MAX_N`=4.
- `rr_arbiter` is a separate sub-module:
  - inputs: `req[N]`, `ptr`;
  - outputs: one-hot `gnt[N]` and encoded `gnt_idx`;
  - purely combinational;
  - `stack_arbiter` owns `rr_ptr` and the FSM.
- The top level instantiates `stack_arbiter` and `stack` side by side.

## Test plan
- Post-reset idle: hold `RST`=1 for 2 cycles, then leave all requests low for 5 cycles → every output stays 0 and `rr_ptr` stays 0.
- Single push/pop (N=2, W=1):
  - Req0 pushes 1 → `REQ_READY[0]` in T, `STK_PUSH` in T+1, `RSP_VALID[0]`=1 with `RSP_ERR`=0 in T+2.
  - Req0 then pops → `RSP_DATA`=1 and `RSP_ERR`=0.
- Contention: both requesters push every cycle from reset → grants go 0, 1, 0, 1. The stack receives the data in grant order; each `RSP_VALID` matches its grant.
- Empty error: pop on an empty stack → no `STK_POP`, `RSP_ERR`=1, `RSP_DATA`=0; the stack stays empty.
- Full error: fill the stack, then push once more → no `STK_PUSH`, `RSP_ERR`=1. A following pop returns the last value pushed.
- Reset mid-transaction: assert `RST` in the `ISSUE` cycle → no strobe, no `RSP_VALID`, and the state returns to `IDLE` with `rr_ptr`=0.
